// File: rtl/full_adder_b_pkg.sv
// Shared constants, types and the golden-sum helper for the full_adder_b block.
// The optional overflow output is enabled by defining FULL_ADDER_B_OVF_EN.
package full_adder_b_pkg;

    localparam int FA_MAX_WIDTH = 64;

    // Widest carry chain the block supports: c[0] = cin up to c[FA_MAX_WIDTH] = cout.
    typedef logic [FA_MAX_WIDTH:0] fa_carry_t;

    // Golden (WIDTH+1)-bit result for operands zero-extended to FA_MAX_WIDTH bits.
    function automatic logic [FA_MAX_WIDTH:0] fa_ref(
        input logic [FA_MAX_WIDTH-1:0] a,
        input logic [FA_MAX_WIDTH-1:0] b,
        input logic                    cin
    );
        return {1'b0, a} + {1'b0, b} + {{FA_MAX_WIDTH{1'b0}}, cin};
    endfunction

endpackage

// File: rtl/full_adder_b_bit_cell.sv
// Combinational 1-bit full adder cell; one link of the full_adder_b ripple chain.
// Pure boolean equations, no selection logic.
module fa_bit_cell
    import full_adder_b_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic co
);

    logic p;

    assign p  = a ^ b;
    assign s  = p ^ cin;
    assign co = (a & b) | (cin & p);

endmodule

// File: rtl/full_adder_b.sv
// Registered WIDTH-bit ripple-carry adder, {cout,sum} <= a + b + cin, one-cycle latency.
// Define FULL_ADDER_B_OVF_EN to add the registered signed-overflow output ovf.
module full_adder_b
    import full_adder_b_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_B_OVF_EN
    ,
    output logic             ovf
`endif
);

    if (WIDTH < 1 || WIDTH > FA_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "full_adder_b: WIDTH=%0d outside legal range 1..%0d", WIDTH, FA_MAX_WIDTH);
    end

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        fa_bit_cell u_cell (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .co  (c[i+1])
        );
    end

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else begin
            sum  <= s;
            cout <= c[WIDTH];
        end
    end

`ifdef FULL_ADDER_B_OVF_EN
    // Signed overflow: carry into the sign bit differs from carry out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else begin
            ovf <= c[WIDTH] ^ c[WIDTH-1];
        end
    end
`endif

endmodule

// File: tb/tb_full_adder_b.sv
// Self-checking bench for full_adder_b at WIDTH=1 and WIDTH=8, random stream plus directed cases.
// Covers ovf as well when built with FULL_ADDER_B_OVF_EN.
module tb_full_adder_b;
    import full_adder_b_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a1, b1, cin1, sum1, cout1;
    logic [7:0] a8, b8, sum8;
    logic       cin8, cout8;
`ifdef FULL_ADDER_B_OVF_EN
    logic       ovf1, ovf8;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    full_adder_b #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef FULL_ADDER_B_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    full_adder_b #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a8),
        .b     (b8),
        .cin   (cin8),
        .sum   (sum8),
        .cout  (cout8)
`ifdef FULL_ADDER_B_OVF_EN
        ,
        .ovf   (ovf8)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Signed overflow from the sign rule: like-signed operands giving an opposite-signed result.
    function automatic logic ovf_model(input logic [63:0] a, input logic [63:0] b,
                                       input logic cin, input int w);
        logic [64:0] t;
        t = {1'b0, a} + {1'b0, b} + {64'd0, cin};
        return (a[w-1] == b[w-1]) && (t[w-1] != a[w-1]);
    endfunction

    // Drive one WIDTH=8 vector, check it one clock later.
    task automatic step8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic [8:0] exp, input logic exp_ovf);
        @(negedge clk);
        a8 = a; b8 = b; cin8 = cin;
        @(negedge clk);
        check(tag, {cout8, sum8}, exp);
`ifdef FULL_ADDER_B_OVF_EN
        check({tag, "_ovf"}, ovf8, exp_ovf);
`else
        if (exp_ovf === 1'bx) $display("unexpected x in ovf expectation for %s", tag);
`endif
    endtask

    initial begin
        logic [1:0]  exp1;
        logic [8:0]  exp8;
        logic        eo1, eo8;
        logic [64:0] r;
        bit          have_prev;

        rst_n = 1'b0;
        a1 = 0; b1 = 0; cin1 = 0;
        a8 = 0; b8 = 0; cin8 = 0;
        repeat (2) @(negedge clk);
        check("reset_w1", {cout1, sum1}, 2'b00);
        check("reset_w8", {cout8, sum8}, 9'h000);
`ifdef FULL_ADDER_B_OVF_EN
        check("reset_ovf8", ovf8, 1'b0);
`endif
        rst_n = 1'b1;

        // WIDTH=1 exhaustive
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            {a1, b1, cin1} = 3'(i);
            exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
            eo1  = ovf_model(64'(a1), 64'(b1), cin1, 1);
            @(negedge clk);
            check($sformatf("w1_exh_%0d", i), {cout1, sum1}, exp1);
`ifdef FULL_ADDER_B_OVF_EN
            check($sformatf("w1_exh_ovf_%0d", i), ovf1, eo1);
`endif
        end

        // Reset held two edges with all-ones inputs, then released
        @(negedge clk);
        a1 = 1; b1 = 1; cin1 = 1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("w1_in_reset", {cout1, sum1}, 2'b00);
        rst_n = 1'b1;
        @(negedge clk);
        check("w1_after_release", {cout1, sum1}, 2'b11);

        // WIDTH=8 boundaries and signed-overflow cases
        step8("w8_ff_00_1", 8'hFF, 8'h00, 1'b1, 9'h100, 1'b0);
        step8("w8_ff_ff_1", 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b0);
        step8("w8_00_00_0", 8'h00, 8'h00, 1'b0, 9'h000, 1'b0);
        step8("w8_7f_01_0", 8'h7F, 8'h01, 1'b0, 9'h080, 1'b1);
        step8("w8_80_ff_0", 8'h80, 8'hFF, 1'b0, 9'h17F, 1'b1);
        step8("w8_01_01_0", 8'h01, 8'h01, 1'b0, 9'h002, 1'b0);

        // Back-to-back random stream with a one-cycle reset pulse in the middle
        have_prev = 1'b0;
        exp1 = '0; exp8 = '0; eo1 = 1'b0; eo8 = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (have_prev) begin
                check("stream_w1", {cout1, sum1}, exp1);
                check("stream_w8", {cout8, sum8}, exp8);
`ifdef FULL_ADDER_B_OVF_EN
                check("stream_ovf1", ovf1, eo1);
                check("stream_ovf8", ovf8, eo8);
`endif
            end
            rst_n = (i == 500) ? 1'b0 : 1'b1;
            a1 = 1'($urandom); b1 = 1'($urandom); cin1 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
            r = fa_ref(64'(a8), 64'(b8), cin8);
            if (rst_n) begin
                exp1 = 2'(a1) + 2'(b1) + 2'(cin1);
                exp8 = r[8:0];
                eo1  = ovf_model(64'(a1), 64'(b1), cin1, 1);
                eo8  = ovf_model(64'(a8), 64'(b8), cin8, 8);
            end else begin
                exp1 = '0; exp8 = '0; eo1 = 1'b0; eo8 = 1'b0;
            end
            have_prev = 1'b1;
        end
        @(negedge clk);
        check("stream_w1_last", {cout1, sum1}, exp1);
        check("stream_w8_last", {cout8, sum8}, exp8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
